// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer: instruction fetch / immediate / execute / interrupt FSM     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int unsigned DATA_W        = 12,
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned IRQ_N         = 24,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned VECTOR_BASE   = 32'h0000_0100,
  parameter int unsigned VECTOR_STRIDE = 4,
  parameter int unsigned ID_W          = (IRQ_N > 1) ? $clog2(IRQ_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              has_imm,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [IRQ_N-1:0]  irq,
  input  logic              irq_en,
  output logic              irq_ack,
  output logic [ID_W-1:0]   irq_id,
  output logic [ADDR_W-1:0] ret_pc,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_IMM   = 4'b0010,
    S_EXEC  = 4'b0100,
    S_IRQ   = 4'b1000
  } state_t;

  localparam logic [ADDR_W-1:0] c_reset_pc   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_vec_base   = ADDR_W'(VECTOR_BASE);
  localparam logic [ADDR_W-1:0] c_vec_stride = ADDR_W'(VECTOR_STRIDE);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   r_imm;
  logic [ID_W-1:0]     r_irq_id;
  logic [ADDR_W-1:0]   r_ret_pc;
  logic                r_irq_ack;
  logic                r_instr_valid;

  logic [ID_W-1:0]     w_irq_sel;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_vector;

  // Descending scan so the lowest set request wins.
  always_comb begin
    w_irq_sel = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq[i]) w_irq_sel = ID_W'(i);
    end
  end

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_target = jump_valid ? jump_addr : r_pc;
  assign w_vector = c_vec_base + ADDR_W'(r_irq_id) * c_vec_stride;

  assign mem_req     = (r_state == S_FETCH) || (r_state == S_IMM);
  assign mem_addr    = mem_req ? r_pc : '0;
  assign instr       = (r_state == S_FETCH) ? mem_rdata : r_instr;
  assign imm         = r_imm;
  assign instr_valid = r_instr_valid;
  assign irq_ack     = r_irq_ack;
  assign irq_id      = r_irq_id;
  assign ret_pc      = r_ret_pc;
  assign state       = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_FETCH;
      r_pc          <= c_reset_pc;
      r_instr       <= '0;
      r_imm         <= '0;
      r_irq_id      <= '0;
      r_ret_pc      <= '0;
      r_irq_ack     <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_instr <= mem_rdata;
            r_pc    <= w_pc_inc;
            if (has_imm) begin
              r_state <= S_IMM;
            end else begin
              r_state       <= S_EXEC;
              r_instr_valid <= 1'b1;
            end
          end
        end
        S_IMM: begin
          if (mem_ready) begin
            r_imm         <= mem_rdata;
            r_pc          <= w_pc_inc;
            r_state       <= S_EXEC;
            r_instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
            // Interrupts are only accepted on the instruction boundary.
            if (irq_en && (|irq)) begin
              r_state   <= S_IRQ;
              r_irq_ack <= 1'b1;
              r_irq_id  <= w_irq_sel;
              r_ret_pc  <= w_target;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_IRQ: begin
          r_pc      <= w_vector;
          r_irq_ack <= 1'b0;
          r_state   <= S_FETCH;
        end
        default: begin
          r_state       <= S_FETCH;
          r_irq_ack     <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer: directed bench with an instruction-level reference model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic [11:0] mem_rdata;
  logic        has_imm;
  logic [11:0] instr;
  logic [11:0] imm;
  logic        instr_valid;
  logic        exec_done;
  logic        jump_valid;
  logic [23:0] jump_addr;
  logic [23:0] irq;
  logic        irq_en;
  logic        irq_ack;
  logic [4:0]  irq_id;
  logic [23:0] ret_pc;
  logic [3:0]  state;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .has_imm(has_imm),
    .instr(instr), .imm(imm), .instr_valid(instr_valid),
    .exec_done(exec_done), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .irq(irq), .irq_en(irq_en), .irq_ack(irq_ack), .irq_id(irq_id),
    .ret_pc(ret_pc), .state(state)
  );

  always #5 clk = ~clk;

  // Program image: word 5 carries an immediate (opcode F), word 6 is its operand.
  function automatic logic [11:0] mem_word(input logic [23:0] a);
    if (a == 24'd5) return 12'hF05;
    if (a == 24'd6) return 12'hA5A;
    return {4'h1, a[7:0]};
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign has_imm   = (instr[11:8] == 4'hF);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 fetch, 1 immediate, 2 execute, 3 interrupt entry.
  int          m_ph;
  logic [23:0] m_pc;
  logic [11:0] m_instr;
  logic [11:0] m_imm;
  logic [4:0]  m_id;
  logic [23:0] m_ret;

  function automatic logic [4:0] lowest_irq(input logic [23:0] r);
    logic [31:0] x;
    x = {8'h0, r} & (~{8'h0, r} + 32'd1);
    return 5'($clog2(x));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph <= 0; m_pc <= 24'd0; m_instr <= 12'd0; m_imm <= 12'd0;
      m_id <= 5'd0; m_ret <= 24'd0;
    end else if (m_ph == 0) begin
      if (mem_ready) begin
        m_instr <= mem_word(m_pc);
        m_pc    <= m_pc + 24'd1;
        m_ph    <= (mem_word(m_pc) >> 8 == 12'hF) ? 1 : 2;
      end
    end else if (m_ph == 1) begin
      if (mem_ready) begin
        m_imm <= mem_word(m_pc);
        m_pc  <= m_pc + 24'd1;
        m_ph  <= 2;
      end
    end else if (m_ph == 2) begin
      if (exec_done) begin
        m_pc <= jump_valid ? jump_addr : m_pc;
        if (irq_en && irq != 24'd0) begin
          m_id  <= lowest_irq(irq);
          m_ret <= jump_valid ? jump_addr : m_pc;
          m_ph  <= 3;
        end else begin
          m_ph <= 0;
        end
      end
    end else begin
      m_pc <= 24'(32'h100 + 32'(m_id) * 32'd4);
      m_ph <= 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_state", 32'(state), 32'(1) << m_ph);
      chk("m_mem_req", 32'(mem_req), (m_ph < 2) ? 32'd1 : 32'd0);
      chk("m_mem_addr", 32'(mem_addr), (m_ph < 2) ? 32'(m_pc) : 32'd0);
      chk("m_instr_valid", 32'(instr_valid), (m_ph == 2) ? 32'd1 : 32'd0);
      chk("m_irq_ack", 32'(irq_ack), (m_ph == 3) ? 32'd1 : 32'd0);
      chk("m_irq_id", 32'(irq_id), 32'(m_id));
      chk("m_ret_pc", 32'(ret_pc), 32'(m_ret));
      chk("m_imm", 32'(imm), 32'(m_imm));
      if (m_ph == 2) chk("m_instr", 32'(instr), 32'(m_instr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b1; exec_done = 1'b1; jump_valid = 1'b0;
    jump_addr = 24'd0; irq = 24'd0; irq_en = 1'b0;
    repeat (2) @(posedge clk);
    #2 cmp_en = 1'b1;
    at_neg();
    chk("rst_state", 32'(state), 32'h1);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_imm", 32'(imm), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_ack", 32'(irq_ack), 32'h0);
    cyc();
    rst = 1'b1;

    // Back-to-back single-word instructions alternate FETCH/EXEC.
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("seq_addr", 32'(mem_addr), 32'(k));
      chk("seq_fetch", 32'(state), 32'h1);
      cyc();
      at_neg();
      chk("seq_exec", 32'(state), 32'h4);
      cyc();
    end

    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("wait_addr", 32'(mem_addr), 32'h4);
      chk("wait_state", 32'(state), 32'h1);
      cyc();
    end
    mem_ready = 1'b1;
    at_neg();
    chk("wait_last", 32'(mem_addr), 32'h4);
    cyc();
    at_neg();
    chk("wait_exec", 32'(state), 32'h4);
    cyc();

    at_neg();
    chk("imm_fetch", 32'(mem_addr), 32'h5);
    cyc();
    at_neg();
    chk("imm_state", 32'(state), 32'h2);
    chk("imm_addr", 32'(mem_addr), 32'h6);
    cyc();
    at_neg();
    chk("imm_value", 32'(imm), 32'hA5A);
    chk("imm_instr", 32'(instr), 32'hF05);
    cyc();
    at_neg();
    chk("after_imm", 32'(mem_addr), 32'h7);
    cyc();
    jump_valid = 1'b1; jump_addr = 24'h00ABCD;
    at_neg();
    chk("imm_kept", 32'(imm), 32'hA5A);
    cyc();
    jump_valid = 1'b0;
    at_neg();
    chk("jump_addr", 32'(mem_addr), 32'h00ABCD);

    // Interrupt taken at an instruction boundary with PC = 0x10.
    cyc();
    jump_valid = 1'b1; jump_addr = 24'h00000F;
    cyc();
    jump_valid = 1'b0; irq = 24'h000088;
    cyc();
    irq_en = 1'b1;
    cyc();
    at_neg();
    chk("irq_ack", 32'(irq_ack), 32'h1);
    chk("irq_id", 32'(irq_id), 32'h3);
    chk("irq_ret", 32'(ret_pc), 32'h10);
    cyc();
    irq = 24'd0;
    at_neg();
    chk("irq_vector", 32'(mem_addr), 32'h10C);
    chk("irq_ack_end", 32'(irq_ack), 32'h0);

    cyc();
    jump_valid = 1'b1; jump_addr = 24'h00000F;
    cyc();
    jump_valid = 1'b0; irq = 24'h000088; irq_en = 1'b0;
    cyc();
    cyc();
    at_neg();
    chk("irq_masked", 32'(mem_addr), 32'h10);

    cyc();
    jump_valid = 1'b1; jump_addr = 24'h000020; irq = 24'h800001; irq_en = 1'b1;
    cyc();
    jump_valid = 1'b0; irq = 24'd0;
    at_neg();
    chk("irq_jump_id", 32'(irq_id), 32'h0);
    chk("irq_jump_ret", 32'(ret_pc), 32'h20);
    cyc();
    at_neg();
    chk("irq_vec0", 32'(mem_addr), 32'h100);

    cyc();
    jump_valid = 1'b1; jump_addr = 24'hFFFFFF; irq_en = 1'b0;
    cyc();
    jump_valid = 1'b0;
    at_neg();
    chk("wrap_top", 32'(mem_addr), 32'hFFFFFF);
    cyc();
    cyc();
    at_neg();
    chk("wrap_zero", 32'(mem_addr), 32'h0);

    // Run to the immediate fetch, then reset asynchronously mid-cycle.
    for (int n = 0; n < 40 && m_ph != 1; n++) cyc();
    chk("reach_imm", 32'(state), 32'h2);
    #1 rst = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'h1);
    chk("async_addr", 32'(mem_addr), 32'h0);
    chk("async_imm", 32'(imm), 32'h0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (6) cyc();
    at_neg();
    chk("post_rst_addr", 32'(mem_addr), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
